// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU sharing arbiter:
//   - alu_control op codes (ADD, SUB, AND, OR, SLT)
//   - bit positions inside the 4-bit flag vector {negative, zero, carry, overflow}
//   - is_legal_op(): tells whether an op code has a defined ALU operation
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam int FLG_NEG   = 3;
   localparam int FLG_ZERO  = 2;
   localparam int FLG_CARRY = 1;
   localparam int FLG_OVF   = 0;

   // Codes 100, 110 and 111 have no ALU operation behind them.
   function automatic logic is_legal_op(input logic [2:0] op);
      logic legal;
      case (op)
         ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
         default:                                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Request/response bundle between NREQ requesters, the response consumer and
// the ALU sharing arbiter.
//   req_valid  [NREQ]     request i valid
//   req_ready  [NREQ]     request i accepted this cycle (one-hot or zero)
//   req_a/b    [NREQ*N]   operands, requester i at [i*N +: N]
//   req_op     [NREQ*3]   op code, requester i at [i*3 +: 3]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id     [IDW]      owner of the response
//   rsp_result [N], rsp_flags [4] {neg, zero, carry, ovf}, rsp_err
// master: requester/consumer side. slave: the arbiter.
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic [NREQ*3-1:0] req_op;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [N-1:0]      rsp_result;
   logic [3:0]        rsp_flags;
   logic              rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
   );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_alu
// The shared combinational N-bit ALU.
//   A, B         operands
//   alu_control  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT (others -> 0)
//   flags        {negative, zero, carry, overflow}
//   Result       operation result
// Carry and overflow come from the adder and are only reported for the
// arithmetic ops (ADD, SUB, SLT); SUB/SLT carry is the no-borrow carry of
// A + ~B + 1. SLT is a signed compare derived from the subtraction.
// ---------------------------------------------------------------------------
module alu_share_arbiter_alu
   import alu_share_arbiter_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   alu_control,
   output logic [3:0]   flags,
   output logic [N-1:0] Result
);

   logic         sub_s;
   logic         arith_s;
   logic [N-1:0] b_eff_s;
   logic [N-1:0] sum_s;
   logic         cout_s;
   logic         ovf_s;

   // Single shared adder plus logic ops, result select and flag generation.
   always_comb begin
      sub_s   = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
      arith_s = (alu_control == ALU_ADD) || sub_s;
      b_eff_s = sub_s ? ~B : B;
      {cout_s, sum_s} = {1'b0, A} + {1'b0, b_eff_s} + {{N{1'b0}}, sub_s};
      // Signed overflow: operands agree in sign, sum disagrees.
      ovf_s = ~(A[N-1] ^ b_eff_s[N-1]) & (A[N-1] ^ sum_s[N-1]);

      case (alu_control)
         ALU_ADD: Result = sum_s;
         ALU_SUB: Result = sum_s;
         ALU_AND: Result = A & B;
         ALU_OR:  Result = A | B;
         ALU_SLT: Result = {{(N-1){1'b0}}, sum_s[N-1] ^ ovf_s};
         default: Result = '0;
      endcase

      flags            = 4'b0000;
      flags[FLG_NEG]   = Result[N-1];
      flags[FLG_ZERO]  = (Result == '0);
      flags[FLG_CARRY] = arith_s & cout_s;
      flags[FLG_OVF]   = arith_s & ovf_s;
   end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_rr_arbiter
// Purely combinational round-robin pick: the first set req bit at or after
// ptr, scanning upward modulo NREQ. Nothing is granted while en is low.
//   req_i     [NREQ]  pending requests
//   en_i              grant allowed this cycle
//   ptr_i     [IDW]   highest-priority index (kept by the parent)
//   gnt_o     [NREQ]  one-hot grant (or zero)
//   gnt_idx_o [IDW]   binary index of the grant (0 when no grant)
// ---------------------------------------------------------------------------
module alu_share_arbiter_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  gnt_idx_o
);

   // Rotating priority scan starting at the pointer.
   always_comb begin
      int   idx;
      logic found;
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end else begin
            idx = idx;
         end
         if (en_i && !found && req_i[idx]) begin
            found          = 1'b1;
            gnt_o[idx]     = 1'b1;
            gnt_idx_o      = IDW'(idx);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU among NREQ requesters with round-robin
// arbitration and a single registered response stage tagged with the id of
// the winning requester. Accept-to-response latency is one cycle; one result
// per cycle is sustained when the consumer keeps rsp_ready high.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_share_arbiter_if.slave (request and response handshakes)
// req_ready is combinational: a grant is only possible when the response
// slot is empty or being drained in the same cycle.
// ---------------------------------------------------------------------------
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int N    = 32,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   alu_share_arbiter_if.slave      bus
);

   logic            slot_free_s;
   logic [NREQ-1:0] gnt_s;
   logic [IDW-1:0]  gnt_idx_s;
   logic            gnt_any_s;

   logic [N-1:0]    alu_a_s;
   logic [N-1:0]    alu_b_s;
   logic [2:0]      alu_op_s;
   logic [N-1:0]    alu_res_s;
   logic [3:0]      alu_flags_s;

   // ALU inputs from the last grant, so the ALU sees stable values when idle.
   logic [N-1:0]    hold_a_q, hold_a_d;
   logic [N-1:0]    hold_b_q, hold_b_d;
   logic [2:0]      hold_op_q, hold_op_d;

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [N-1:0]    rsp_result_q, rsp_result_d;
   logic [3:0]      rsp_flags_q, rsp_flags_d;
   logic            rsp_err_q, rsp_err_d;

   assign slot_free_s = !rsp_valid_q || bus.rsp_ready;

   alu_share_arbiter_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req_i     (bus.req_valid),
      .en_i      (slot_free_s),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt_s),
      .gnt_idx_o (gnt_idx_s)
   );

   assign gnt_any_s     = |gnt_s;
   assign bus.req_ready = gnt_s;

   // Operand mux: the granted requester drives the ALU, otherwise the held values.
   always_comb begin
      alu_a_s  = hold_a_q;
      alu_b_s  = hold_b_q;
      alu_op_s = hold_op_q;
      if (gnt_any_s) begin
         alu_a_s  = bus.req_a[int'(gnt_idx_s)*N +: N];
         alu_b_s  = bus.req_b[int'(gnt_idx_s)*N +: N];
         alu_op_s = bus.req_op[int'(gnt_idx_s)*3 +: 3];
      end else begin
         alu_a_s  = hold_a_q;
         alu_b_s  = hold_b_q;
         alu_op_s = hold_op_q;
      end
      hold_a_d  = alu_a_s;
      hold_b_d  = alu_b_s;
      hold_op_d = alu_op_s;
   end

   alu_share_arbiter_alu #(
      .N (N)
   ) u_alu (
      .A           (alu_a_s),
      .B           (alu_b_s),
      .alu_control (alu_op_s),
      .flags       (alu_flags_s),
      .Result      (alu_res_s)
   );

   // Response register next state, illegal-op masking and pointer advance.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_err_d    = rsp_err_q;
      ptr_d        = ptr_q;
      if (gnt_any_s) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx_s;
         if (is_legal_op(alu_op_s)) begin
            rsp_result_d = alu_res_s;
            rsp_flags_d  = alu_flags_s;
            rsp_err_d    = 1'b0;
         end else begin
            rsp_result_d = '0;
            rsp_flags_d  = 4'b0000;
            rsp_err_d    = 1'b1;
         end
         if (gnt_idx_s == IDW'(NREQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx_s + IDW'(1);
         end
      end else if (rsp_valid_q && bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_a_q     <= '0;
         hold_b_q     <= '0;
         hold_op_q    <= 3'b000;
         ptr_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 4'b0000;
         rsp_err_q    <= 1'b0;
      end else begin
         hold_a_q     <= hold_a_d;
         hold_b_q     <= hold_b_d;
         hold_op_q    <= hold_op_d;
         ptr_q        <= ptr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule
